// File: rtl/seq_pkg.sv
// Shared definitions for the address sequencer: repeat FSM states and
// default timing constants.
package seq_pkg;

    localparam int unsigned TICK_DIV_DEF  = 32768;
    localparam int unsigned HIST_LEN_DEF  = 8;
    localparam int unsigned RPT_DELAY_DEF = 64;
    localparam int unsigned RPT_RATE_DEF  = 8;

    localparam int unsigned NUM_BTN = 3;
    localparam int unsigned BTN_INC = 0;
    localparam int unsigned BTN_DEC = 1;
    localparam int unsigned BTN_WR  = 2;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        WAIT_DELAY,
        REPEAT
    } rpt_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One active-low push button: two-flop synchroniser, tick-sampled history,
// debounced stable state and a one-cycle press event.
module btn_debounce
    import seq_pkg::*;
#(
    parameter int unsigned HIST_LEN = HIST_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_n,
    input  logic i_tick,
    output logic o_held,
    output logic o_press
);

    localparam int unsigned      CW       = $clog2(HIST_LEN);
    localparam logic [CW-1:0]    REL_LAST = CW'(HIST_LEN - 1);

    logic [1:0]          r_sync;
    logic [HIST_LEN-1:0] r_hist;
    logic [CW-1:0]       r_rel_cnt;
    logic                r_armed;
    logic                r_stable;
    logic                r_press;
    logic [HIST_LEN-1:0] w_hist_next;

    assign w_hist_next = {r_hist[HIST_LEN-2:0], r_sync[1]};

    // Held means debounced-pressed and still physically down, so a release
    // cuts auto-repeat short without waiting for the release debounce.
    assign o_held  = r_stable & ~r_sync[1];
    assign o_press = r_press;

    // NOTE: every state register here uses <= so all flops sample the values
    // from before the edge, exactly like the hardware they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync    <= 2'b11;
            r_hist    <= '1;
            r_rel_cnt <= '0;
            r_armed   <= 1'b0;
            r_stable  <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn_n};
            r_press <= 1'b0;
            if (i_tick) begin
                r_hist <= w_hist_next;
                // Arm only after HIST_LEN real released samples, so a button
                // held through reset cannot fire until released and re-pressed.
                if (!r_sync[1]) begin
                    r_rel_cnt <= '0;
                end else if (r_rel_cnt == REL_LAST) begin
                    r_armed <= 1'b1;
                end else begin
                    r_rel_cnt <= r_rel_cnt + 1'b1;
                end
                if (w_hist_next == '1) begin
                    r_stable <= 1'b0;
                end else if ((w_hist_next == '0) && r_armed && !r_stable) begin
                    r_stable <= 1'b1;
                    r_press  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/addr_sequencer.sv
// Button-driven 8-bit address sequencer with debounced inc/dec auto-repeat
// and a one-cycle write strobe carrying the DIP switch value.
module addr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
    parameter int unsigned HIST_LEN  = HIST_LEN_DEF,
    parameter int unsigned RPT_DELAY = RPT_DELAY_DEF,
    parameter int unsigned RPT_RATE  = RPT_RATE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_wr,
    input  logic [7:0] dip,
    output logic [7:0] addr,
    output logic       write,
    output logic [7:0] wr_data
);

    localparam int unsigned    TCW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TCW-1:0] TICK_LAST  = TCW'(TICK_DIV - 1);
    localparam int unsigned    RPT_MAX    = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int unsigned    RCW        = $clog2(RPT_MAX + 1);
    localparam logic [RCW-1:0] DELAY_LAST = RCW'(RPT_DELAY - 1);
    localparam logic [RCW-1:0] RATE_LAST  = RCW'(RPT_RATE - 1);

    logic [TCW-1:0]     r_tick_cnt;
    logic               w_tick;
    logic [NUM_BTN-1:0] w_btn_n;
    logic [NUM_BTN-1:0] w_held;
    logic [NUM_BTN-1:0] w_press;
    logic               w_unused_wr_held;

    rpt_state_t         r_state        [2];
    rpt_state_t         w_state_next   [2];
    logic [RCW-1:0]     r_rpt_cnt      [2];
    logic [RCW-1:0]     w_rpt_cnt_next [2];
    logic [1:0]         w_step;

    logic [7:0]         r_addr;
    logic               r_write;
    logic [7:0]         r_wr_data;

    assign w_tick           = (r_tick_cnt == TICK_LAST);
    assign w_btn_n          = {btn_wr, btn_dec, btn_inc};
    assign w_unused_wr_held = w_held[BTN_WR];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        end
    end

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        btn_debounce #(
            .HIST_LEN (HIST_LEN)
        ) u_btn_debounce (
            .clk     (clk),
            .rst     (rst),
            .i_btn_n (w_btn_n[b]),
            .i_tick  (w_tick),
            .o_held  (w_held[b]),
            .o_press (w_press[b])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                r_state[d]   <= IDLE;
                r_rpt_cnt[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                r_state[d]   <= w_state_next[d];
                r_rpt_cnt[d] <= w_rpt_cnt_next[d];
            end
        end
    end

    // NOTE: each output of this block is given a default before the case so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_step = 2'b00;
        for (int d = 0; d < 2; d++) begin
            w_state_next[d]   = r_state[d];
            w_rpt_cnt_next[d] = r_rpt_cnt[d];
            case (r_state[d])
                IDLE: begin
                    if (w_press[d]) w_state_next[d] = STEP;
                end
                STEP: begin
                    w_step[d]         = 1'b1;
                    w_rpt_cnt_next[d] = '0;
                    w_state_next[d]   = w_held[d] ? WAIT_DELAY : IDLE;
                end
                WAIT_DELAY: begin
                    if (!w_held[d]) begin
                        w_state_next[d] = IDLE;
                    end else if (w_tick) begin
                        if (r_rpt_cnt[d] == DELAY_LAST) begin
                            w_state_next[d]   = REPEAT;
                            w_rpt_cnt_next[d] = '0;
                        end else begin
                            w_rpt_cnt_next[d] = r_rpt_cnt[d] + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (!w_held[d]) begin
                        w_state_next[d] = IDLE;
                    end else if (w_tick) begin
                        if (r_rpt_cnt[d] == RATE_LAST) begin
                            w_step[d]         = 1'b1;
                            w_rpt_cnt_next[d] = '0;
                        end else begin
                            w_rpt_cnt_next[d] = r_rpt_cnt[d] + 1'b1;
                        end
                    end
                end
                default: w_state_next[d] = IDLE;
            endcase
        end
    end

    // The strobe is registered from the press event, so any step landing in
    // the write cycle only reaches addr after it; writes see the old address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr    <= 8'h00;
            r_write   <= 1'b0;
            r_wr_data <= 8'h00;
        end else begin
            r_write <= w_press[BTN_WR];
            if (w_press[BTN_WR]) r_wr_data <= dip;
            if (w_step == 2'b01) begin
                r_addr <= r_addr + 8'd1;
            end else if (w_step == 2'b10) begin
                r_addr <= r_addr - 8'd1;
            end
        end
    end

    assign addr    = r_addr;
    assign write   = r_write;
    assign wr_data = r_wr_data;

endmodule

// File: tb/tb_addr_sequencer.sv
// Self-checking bench for addr_sequencer: directed button scenarios plus a
// random phase, all checked against a tick-level behavioural model.
module tb_addr_sequencer;

    localparam int TICK_DIV  = 4;
    localparam int HIST_LEN  = 8;
    localparam int RPT_DELAY = 4;
    localparam int RPT_RATE  = 2;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       btn_inc = 1'b1;
    logic       btn_dec = 1'b1;
    logic       btn_wr  = 1'b1;
    logic [7:0] dip     = 8'h00;
    logic [7:0] addr;
    logic       write;
    logic [7:0] wr_data;

    always #5 clk = ~clk;

    addr_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .HIST_LEN  (HIST_LEN),
        .RPT_DELAY (RPT_DELAY),
        .RPT_RATE  (RPT_RATE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_inc (btn_inc),
        .btn_dec (btn_dec),
        .btn_wr  (btn_wr),
        .dip     (dip),
        .addr    (addr),
        .write   (write),
        .wr_data (wr_data)
    );

    int n_checks = 0;
    int n_errors = 0;
    int wr_seen  = 0;

    // Reference model, advanced once per sample tick (index 0 inc, 1 dec, 2 wr).
    int         m_run    [3];
    logic       m_last   [3];
    bit         m_armed  [3];
    bit         m_stable [3];
    bit         m_rep    [2];
    int         m_t0     [2];
    int         m_n;
    logic [7:0] m_addr;
    logic [7:0] m_wr_data;
    bit         m_wr_pend;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            m_run[b]    = 0;
            m_last[b]   = 1'b1;
            m_armed[b]  = 1'b0;
            m_stable[b] = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            m_rep[d] = 1'b0;
            m_t0[d]  = 0;
        end
        m_n       = 0;
        m_addr    = 8'h00;
        m_wr_data = 8'h00;
        m_wr_pend = 1'b0;
    endtask

    function automatic logic [7:0] stepped(input logic [7:0] a, input int dir);
        return (dir == 0) ? a + 8'd1 : a - 8'd1;
    endfunction

    task automatic model_tick(input logic [2:0] lv);
        int h;
        m_n++;
        for (int d = 0; d < 2; d++) begin
            if (m_rep[d]) begin
                if (lv[d]) begin
                    m_rep[d] = 1'b0;
                end else begin
                    h = m_n - m_t0[d];
                    if (h >= RPT_DELAY + RPT_RATE && (h - RPT_DELAY) % RPT_RATE == 0)
                        m_addr = stepped(m_addr, d);
                end
            end
        end
        for (int b = 0; b < 3; b++) begin
            m_run[b]  = (lv[b] == m_last[b]) ? m_run[b] + 1 : 1;
            m_last[b] = lv[b];
            if (m_run[b] >= HIST_LEN) begin
                if (lv[b]) begin
                    m_armed[b]  = 1'b1;
                    m_stable[b] = 1'b0;
                end else if (m_armed[b] && !m_stable[b]) begin
                    m_stable[b] = 1'b1;
                    if (b == 2) begin
                        m_wr_pend = 1'b1;
                    end else begin
                        m_rep[b] = 1'b1;
                        m_t0[b]  = m_n;
                        m_addr   = stepped(m_addr, b);
                    end
                end
            end
        end
    endtask

    // One tick period: entered on the falling edge of the cycle after a tick,
    // returns on the matching edge of the next period.
    task automatic period(input logic inc, input logic dec, input logic wr, input logic [7:0] d);
        btn_inc = inc;
        btn_dec = dec;
        btn_wr  = wr;
        dip     = d;
        @(negedge clk);
        check("write", {7'b0, write}, {7'b0, m_wr_pend});
        if (write) wr_seen++;
        if (m_wr_pend) m_wr_data = d;
        m_wr_pend = 1'b0;
        check("wr_data", wr_data, m_wr_data);
        @(negedge clk);
        check("addr", addr, m_addr);
        @(negedge clk);
        check("write_idle", {7'b0, write}, 8'h00);
        model_tick({wr, dec, inc});
        @(negedge clk);
    endtask

    task automatic hold(input logic inc, input logic dec, input logic wr, input int n);
        for (int i = 0; i < n; i++) period(inc, dec, wr, 8'($urandom));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] lvl;
        int         rem [3];

        model_reset();
        repeat (3) @(negedge clk);
        check("rst_addr", addr, 8'h00);
        check("rst_write", {7'b0, write}, 8'h00);
        check("rst_wr_data", wr_data, 8'h00);
        rst = 1'b1;

        hold(1, 1, 1, 10);

        // Single inc press.
        hold(0, 1, 1, 8);
        hold(1, 1, 1, 12);
        check("inc_once", addr, 8'h01);

        // Dec to 0x00, wrap to 0xFF, inc back to 0x00.
        hold(1, 0, 1, 8);
        hold(1, 1, 1, 12);
        check("dec_to_00", addr, 8'h00);
        hold(1, 0, 1, 8);
        hold(1, 1, 1, 12);
        check("dec_wrap", addr, 8'hFF);
        hold(0, 1, 1, 8);
        hold(1, 1, 1, 12);
        check("inc_wrap", addr, 8'h00);

        // Short glitch never becomes stable.
        hold(0, 1, 1, 3);
        hold(1, 1, 1, 10);
        check("glitch", addr, 8'h00);

        // Auto-repeat: held 20 ticks after becoming stable.
        hold(0, 1, 1, 8 + 20);
        hold(1, 1, 1, 12);
        check("repeat_20", addr, 8'h09);

        // Shorter repeat to reach 0x10.
        hold(0, 1, 1, 8 + 16);
        hold(1, 1, 1, 12);
        check("repeat_16", addr, 8'h10);

        // Write press held for a long time yields one strobe with the sampled dip.
        wr_seen = 0;
        for (int i = 0; i < 9; i++) period(1, 1, 0, 8'hA5);
        hold(1, 1, 0, 49);
        hold(1, 1, 1, 12);
        check("wr_pulses", 8'(wr_seen), 8'h01);
        check("wr_addr", addr, 8'h10);
        check("wr_value", wr_data, 8'hA5);

        // Simultaneous inc and dec cancel.
        hold(0, 0, 1, 8);
        hold(1, 1, 1, 12);
        check("inc_dec_cancel", addr, 8'h10);

        // Reset during REPEAT with a write press pending, inc held through reset.
        hold(0, 1, 1, 10);
        hold(0, 1, 0, 8);
        rst = 1'b0;
        #1;
        check("midrst_addr", addr, 8'h00);
        check("midrst_write", {7'b0, write}, 8'h00);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        hold(0, 1, 1, 20);
        check("held_thru_rst", addr, 8'h00);
        hold(1, 1, 1, 12);
        hold(0, 1, 1, 8);
        hold(1, 1, 1, 12);
        check("repress_after_rst", addr, 8'h01);

        // Random run-length button activity.
        lvl = 3'b111;
        for (int b = 0; b < 3; b++) rem[b] = 0;
        for (int p = 0; p < 400; p++) begin
            for (int b = 0; b < 3; b++) begin
                if (rem[b] == 0) begin
                    lvl[b] = ~lvl[b];
                    rem[b] = int'($urandom_range(1, 30));
                end
                rem[b]--;
            end
            period(lvl[0], lvl[1], lvl[2], 8'($urandom));
        end
        hold(1, 1, 1, 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
